// File: rtl/scrambler_lfsr_stream_pkg.sv
// Shared constants, FSM state type and the 8-step LFSR helper for the byte scrambler.
package scrambler_lfsr_stream_pkg;

  localparam logic [31:0] SCR_POLY     = 32'h8020_0003;
  localparam logic [31:0] SCR_SEED_FIX = 32'hACE1_ACE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } scr_state_e;

  // Returns {state after 8 steps, ks}; ks[0] is the first keystream bit produced.
  function automatic logic [39:0] lfsr_step8(input logic [31:0] state,
                                             input logic [31:0] poly);
    logic [31:0] s;
    logic [7:0]  ks;
    s = state;
    for (int i = 0; i < 8; i++) begin
      ks[i] = s[31];
      s     = {s[30:0], ^(s & poly)};
    end
    return {s, ks};
  endfunction

endpackage

// File: rtl/scrambler_lfsr_stream_step8.sv
// Combinational eight-step advance of the Fibonacci LFSR plus the byte of keystream it yields.
module scrambler_lfsr_stream_step8
  import scrambler_lfsr_stream_pkg::*;
#(
  parameter logic [31:0] POLY = SCR_POLY
) (
  input  logic [31:0] cur,
  output logic [31:0] nxt,
  output logic [7:0]  ks
);

  assign {nxt, ks} = lfsr_step8(cur, POLY);

endmodule

// File: rtl/scrambler_lfsr_stream.sv
// Seeded LFSR byte scrambler: one frame per seed load, valid/ready on both sides,
// single output register so input and output can both move every cycle.
module scrambler_lfsr_stream
  import scrambler_lfsr_stream_pkg::*;
#(
  parameter logic [31:0] POLY     = SCR_POLY,
  parameter logic [31:0] SEED_FIX = SCR_SEED_FIX,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seed,
  input  logic             seed_load,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [7:0]       din,
  input  logic             din_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       dout,
  output logic             dout_last,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             seed_err
);

  scr_state_e       state_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_nxt;
  logic [7:0]       ks;
  logic [7:0]       dout_q;
  logic             dout_valid_q;
  logic             dout_last_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             seed_err_q;
  logic             accept;
  logic             pop;

  scrambler_lfsr_stream_step8 #(
    .POLY (POLY)
  ) u_step8 (
    .cur (lfsr_q),
    .nxt (lfsr_nxt),
    .ks  (ks)
  );

  // Output register is free when empty or being drained this cycle.
  assign din_ready = (state_q == S_RUN) && (!dout_valid_q || dout_ready);
  assign accept    = din_valid && din_ready;
  assign pop       = dout_valid_q && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      byte_cnt_q   <= '0;
      seed_err_q   <= 1'b0;
    end else begin
      // A load while busy flags an error; a load taken in IDLE clears it.
      if (seed_load) begin
        seed_err_q <= (state_q != S_IDLE);
      end
      unique case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q     <= (seed == '0) ? SEED_FIX : seed;
            byte_cnt_q <= '0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            dout_q       <= din ^ ks;
            dout_last_q  <= din_last;
            dout_valid_q <= 1'b1;
            lfsr_q       <= lfsr_nxt;
            if (byte_cnt_q != '1) begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
            if (din_last) begin
              state_q <= S_DRAIN;
            end
          end else if (pop) begin
            dout_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (pop || !dout_valid_q) begin
            dout_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q != S_IDLE);
  assign byte_cnt   = byte_cnt_q;
  assign seed_err   = seed_err_q;

endmodule

// File: tb/tb_scrambler_lfsr_stream.sv
// Bench for scrambler_lfsr_stream: bit-serial LFSR model with a frame-level scoreboard,
// two DUTs (16-bit and 4-bit byte counters) driven in lockstep.
module tb_scrambler_lfsr_stream;

  localparam logic [31:0] M_POLY = 32'h8020_0003;
  localparam logic [31:0] M_FIX  = 32'hACE1_ACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed = '0;
  logic        seed_load = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = '0;
  logic        din_last = 1'b0;
  logic        dout_ready = 1'b0;

  logic        din_ready, dout_valid, dout_last, busy, seed_err;
  logic [7:0]  dout;
  logic [15:0] byte_cnt;
  logic        din_ready4, dout_valid4, dout_last4, busy4, seed_err4;
  logic [7:0]  dout4;
  logic [3:0]  byte_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scrambler_lfsr_stream dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load),
    .din_valid(din_valid), .din_ready(din_ready), .din(din), .din_last(din_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .dout_last(dout_last),
    .busy(busy), .byte_cnt(byte_cnt), .seed_err(seed_err)
  );

  scrambler_lfsr_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load),
    .din_valid(din_valid), .din_ready(din_ready4), .din(din), .din_last(din_last),
    .dout_valid(dout_valid4), .dout_ready(dout_ready), .dout(dout4), .dout_last(dout_last4),
    .busy(busy4), .byte_cnt(byte_cnt4), .seed_err(seed_err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial keystream: one tap scan and one shift per bit.
  function automatic logic [7:0] model_ks(input logic [31:0] s_in, output logic [31:0] s_out);
    logic [31:0] s;
    logic [7:0]  k;
    logic        fb;
    s = s_in;
    for (int b = 0; b < 8; b++) begin
      k[b] = s[31];
      fb = 1'b0;
      for (int j = 0; j < 32; j++) if (M_POLY[j]) fb = fb ^ s[j];
      s = (s << 1) | {31'b0, fb};
    end
    s_out = s;
    return k;
  endfunction

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } item_t;

  item_t       q[$];
  logic [31:0] m_lfsr = '0;
  logic        m_busy = 1'b0;
  logic        m_run  = 1'b0;
  logic        m_err  = 1'b0;
  int          m_cnt  = 0;

  // Scoreboard: check current outputs, then advance the model by what the next edge does.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dout_valid", {31'b0, dout_valid | dout_valid4}, 0);
      chk("rst_dout", {24'b0, dout | dout4}, 0);
      chk("rst_dout_last", {31'b0, dout_last | dout_last4}, 0);
      chk("rst_busy", {31'b0, busy | busy4}, 0);
      chk("rst_byte_cnt", {16'b0, byte_cnt}, 0);
      chk("rst_seed_err", {31'b0, seed_err | seed_err4}, 0);
      chk("rst_din_ready", {31'b0, din_ready | din_ready4}, 0);
      q.delete();
      m_busy = 1'b0;
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_lfsr = '0;
    end else begin
      logic  exp_rdy;
      logic  pop;
      logic  push;
      item_t it;
      logic [7:0] k;
      logic [31:0] ns;
      chk("dout_valid", {31'b0, dout_valid}, {31'b0, q.size() != 0});
      chk("dout_valid4", {31'b0, dout_valid4}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("dout", {24'b0, dout}, {24'b0, q[0].d});
        chk("dout4", {24'b0, dout4}, {24'b0, q[0].d});
        chk("dout_last", {31'b0, dout_last}, {31'b0, q[0].l});
        chk("dout_last4", {31'b0, dout_last4}, {31'b0, q[0].l});
      end
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("busy4", {31'b0, busy4}, {31'b0, m_busy});
      chk("byte_cnt", {16'b0, byte_cnt}, 32'(m_cnt > 65535 ? 65535 : m_cnt));
      chk("byte_cnt4", {28'b0, byte_cnt4}, 32'(m_cnt > 15 ? 15 : m_cnt));
      chk("seed_err", {31'b0, seed_err}, {31'b0, m_err});
      chk("seed_err4", {31'b0, seed_err4}, {31'b0, m_err});
      exp_rdy = m_run && (q.size() == 0 || dout_ready);
      chk("din_ready", {31'b0, din_ready}, {31'b0, exp_rdy});
      chk("din_ready4", {31'b0, din_ready4}, {31'b0, exp_rdy});

      pop  = (q.size() != 0) && dout_ready;
      push = din_valid && exp_rdy;
      if (seed_load) begin
        if (!m_busy) begin
          m_lfsr = (seed == 0) ? M_FIX : seed;
          m_cnt  = 0;
          m_err  = 1'b0;
          m_busy = 1'b1;
          m_run  = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (pop) begin
        it = q.pop_front();
        if (it.l) m_busy = 1'b0;
      end
      if (push) begin
        k = model_ks(m_lfsr, ns);
        m_lfsr = ns;
        q.push_back('{d: din ^ k, l: din_last});
        m_cnt++;
        if (din_last) m_run = 1'b0;
      end
    end
  end

  task automatic load(input logic [31:0] sd);
    @(posedge clk); #1;
    seed = sd;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask

  task automatic wait_idle(input int mode);
    int k;
    for (k = 0; k < 400 && busy; k++) begin
      @(posedge clk); #1;
      dout_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("idle_reached", {31'b0, busy}, 0);
    dout_ready = 1'b1;
  endtask

  // mode 0: dout_ready held high; mode 1: random 50%. inj: byte index at which seed_load pulses.
  task automatic send_frame(input int n, input int mode, input int pat, input int inj,
                            output int stalls);
    int i;
    int guard;
    i = 0;
    guard = 0;
    stalls = 0;
    while (i < n && guard < 5000) begin
      @(posedge clk); #1;
      din_valid  = 1'b1;
      din        = 8'(i * 37 + pat);
      din_last   = (i == n - 1);
      dout_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      seed_load  = (i == inj);
      @(negedge clk);
      if (din_ready) i++;
      else stalls++;
      guard++;
    end
    chk("frame_sent", 32'(i), 32'(n));
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_last  = 1'b0;
    seed_load = 1'b0;
    wait_idle(mode);
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] s2;
    logic [7:0]  k;
    int          st;

    // Pin the model: first keystream bytes are the bit-reversed top seed bytes.
    k = model_ks(32'h1234_5678, s);
    chk("model_ks0", {24'b0, k}, 32'h48);
    k = model_ks(s, s2);
    chk("model_ks1", {24'b0, k}, 32'h2C);
    k = model_ks(s2, s);
    chk("model_ks2", {24'b0, k}, 32'h6A);
    k = model_ks(s, s2);
    chk("model_ks3", {24'b0, k}, 32'h1E);
    k = model_ks(32'hACE1_ACE1, s);
    chk("model_ks_fix", {24'b0, k}, 32'h35);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy}, 0);

    // Reset mid-RUN with a byte held in the output register.
    load(32'hDEAD_BEEF);
    @(posedge clk); #1;
    din_valid  = 1'b1;
    din        = 8'h11;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, dout_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, dout_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_cnt", {16'b0, byte_cnt}, 0);
    @(posedge clk); #1 rst = 1'b0;
    dout_ready = 1'b1;

    // Zero seed takes the fixed substitute; plaintext 0 exposes the keystream.
    load(32'h0);
    @(posedge clk); #1;
    din_valid  = 1'b1;
    din        = 8'h00;
    din_last   = 1'b1;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_last  = 1'b0;
    chk("zero_seed_dout", {24'b0, dout}, 32'h35);
    chk("zero_seed_last", {31'b0, dout_last}, 1);
    wait_idle(0);

    // 64 bytes at full rate.
    load(32'h1234_5678);
    send_frame(64, 0, 5, -1, st);
    chk("full_rate_stalls", 32'(st), 0);
    chk("cnt64", {16'b0, byte_cnt}, 64);
    chk("cnt4_sat", {28'b0, byte_cnt4}, 32'hF);

    // Same stream under random backpressure.
    load(32'h1234_5678);
    send_frame(64, 1, 5, -1, st);
    chk("cnt64_bp", {16'b0, byte_cnt}, 64);

    // seed_load during RUN flags an error but does not disturb the stream.
    load(32'hCAFE_0001);
    send_frame(10, 0, 9, 3, st);
    chk("seed_err_set", {31'b0, seed_err}, 1);
    load(32'h0BAD_F00D);
    chk("seed_err_clr", {31'b0, seed_err}, 0);
    send_frame(20, 1, 1, -1, st);
    chk("cnt20", {16'b0, byte_cnt}, 20);
    chk("cnt20_4bit", {28'b0, byte_cnt4}, 32'hF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
